// File: rtl/sort_pkg.sv
// Shared defaults and state encoding for the sorted-frame streamer.
package sort_pkg;

    localparam int N_WORDS_DEF = 10;
    localparam int DATA_W_DEF  = 32;

    // IDLE: waiting for a frame; STREAM: emitting buffered words one per beat.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/sort_order_checker.sv
// Sticky ordering monitor: flags any handshaken word that is smaller
// (unsigned) than the previously handshaken word of the same frame.
module sort_order_checker #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              err_o
);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic              err_q, err_d;

    // Next-state: remember the last accepted word, latch any descent.
    always_comb begin
        prev_d = prev_q;
        err_d  = err_q;
        if (beat_i) begin
            prev_d = data_i;
            if (!first_i && (data_i < prev_q)) begin
                err_d = 1'b1;
            end
        end
    end

    // Registers; the flag only clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/sort_result_streamer.sv
// Captures a sorted frame from a combinational sorter and streams it out
// one word per beat. Optional ordering check enabled by SORT_ORDER_CHECK_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid/data stable until that edge; ready may
// depend on anything except a combinational path from the same valid.
module sort_result_streamer
    import sort_pkg::*;
#(
    parameter int N_WORDS = N_WORDS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    localparam int IDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data [N_WORDS],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic [15:0]       frame_cnt,
    output logic              order_err,
    output state_e            dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0] buf_q [N_WORDS];
    logic              load;

    // Next-state logic: capture in IDLE, walk the buffer in STREAM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = IDLE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Frame buffer: only written on capture, so it is frozen mid-frame.
    always_ff @(posedge clk) begin
        if (load) begin
            buf_q <= in_data;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == STREAM);
    assign out_data  = buf_q[idx_q];
    assign out_index = idx_q;
    assign out_last  = (idx_q == LAST_IDX);
    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

`ifdef SORT_ORDER_CHECK_EN
    sort_order_checker #(
        .DATA_W (DATA_W)
    ) u_order_checker (
        .clk     (clk),
        .rst     (rst),
        .beat_i  (out_valid && out_ready),
        .first_i (idx_q == '0),
        .data_i  (out_data),
        .err_o   (order_err)
    );
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_streamer.sv
// Bench for sort_result_streamer: table of frames plus hand-written
// stall, back-pressure, mid-frame reset, ordering and wrap sequences.
module tb_sort_result_streamer;
  import sort_pkg::*;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = 4;
  localparam int EW = 1 + IW + W;
`ifdef SORT_ORDER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct packed {
    frame_t      w;
    logic [3:0]  pat;
    logic [7:0]  exp_ticks;
    logic [15:0] exp_cnt;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data [N];
  logic          in_ready, out_valid, out_last, order_err;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic [15:0]   frame_cnt;
  state_e        dbg_state;

  sort_result_streamer #(.N_WORDS(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .frame_cnt (frame_cnt),
    .order_err (order_err),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data;
  logic [IW-1:0] prev_idx;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_data", 64'(out_data), 64'(prev_data));
        check("stall_hold_index", 64'(out_index), 64'(prev_idx));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=data %0h idx %0d expected=no beat", out_data, out_index);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 64'({out_last, out_index, out_data}), 64'(mon_e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_frame(input frame_t w);
    for (int i = 0; i < N; i++) in_data[i] = w[i];
  endtask

  task automatic capture(input frame_t w, input logic keep_valid);
    int g;
    g = 0;
    load_frame(w);
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      tick;
      g++;
    end
    check("capture_ready_seen", 64'(in_ready), 64'd1);
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), IW'(i), w[i]});
    tick;
    if (!keep_valid) in_valid = 1'b0;
    check("in_ready_after_capture", 64'(in_ready), 64'd0);
    check("out_valid_after_capture", 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input logic [3:0] pat, output int k);
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      out_ready = pat[k % 4];
      tick;
      k++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
  endtask

  task automatic check_idle(input string name, input logic [15:0] cnt, input logic err);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(cnt));
    check({name, "_order_err"}, 64'(order_err), 64'(err));
  endtask

  // ---------------- stimulus ----------------
  vec_t   vecs [5];
  frame_t fa, fb, fe;
  int     k;

  initial begin
    for (int i = 0; i < N; i++) in_data[i] = '0;

    // Table: sorted frames, ready pattern, expected ticks to drain, expected frame_cnt.
    for (int i = 0; i < N; i++) vecs[0].w[i] = W'(i);
    vecs[0].pat = 4'b1111; vecs[0].exp_ticks = 8'd10; vecs[0].exp_cnt = 16'd1;
    vecs[1].w = {32'hFFFF_FFFF, 32'd65535, 32'd1000, 32'd100, 32'd20,
                 32'd20, 32'd10, 32'd5, 32'd5, 32'd5};
    vecs[1].pat = 4'b1001; vecs[1].exp_ticks = 8'd20; vecs[1].exp_cnt = 16'd2;
    for (int i = 0; i < N; i++) vecs[2].w[i] = 32'hFFFF_FFFF;
    vecs[2].pat = 4'b1010; vecs[2].exp_ticks = 8'd20; vecs[2].exp_cnt = 16'd3;
    for (int i = 0; i < N; i++) vecs[3].w[i] = '0;
    vecs[3].pat = 4'b0111; vecs[3].exp_ticks = 8'd13; vecs[3].exp_cnt = 16'd4;
    vecs[4].w[0] = W'($urandom_range(0, 1000));
    for (int i = 1; i < N; i++) vecs[4].w[i] = vecs[4].w[i-1] + W'($urandom_range(0, 1000));
    vecs[4].pat = 4'b1111; vecs[4].exp_ticks = 8'd10; vecs[4].exp_cnt = 16'd5;

    // Reset with a frame offered: it must not be taken while rst is high.
    in_valid = 1'b1;
    tick;
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check_idle("rst", 16'd0, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b0;
    check_idle("post_rst", 16'd0, 1'b0);

    for (int v = 0; v < 5; v++) begin
      capture(vecs[v].w, 1'b0);
      drain(vecs[v].pat, k);
      check($sformatf("vec%0d_ticks", v), 64'(k), 64'(vecs[v].exp_ticks));
      check_idle($sformatf("vec%0d", v), vecs[v].exp_cnt, 1'b0);
    end

    // Frame offered during STREAM is ignored until IDLE.
    for (int i = 0; i < N; i++) fa[i] = W'(100 + 3 * i);
    for (int i = 0; i < N; i++) fb[i] = W'(500 + i);
    capture(fa, 1'b1);
    load_frame(fb);
    drain(4'b1111, k);
    check("hold_off_ticks", 64'(k), 64'd10);
    check("hold_off_in_ready", 64'(in_ready), 64'd1);
    check("hold_off_cnt", 64'(frame_cnt), 64'd6);
    capture(fb, 1'b0);
    drain(4'b1111, k);
    check_idle("second_frame", 16'd7, 1'b0);

    // Reset after four beats discards the rest of the frame.
    capture(fa, 1'b0);
    out_ready = 1'b1;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    tick;
    check("midrst_idle_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < N; i++) fb[i] = W'(7 * i);
    capture(fb, 1'b0);
    drain(4'b1111, k);
    check("midrst_new_ticks", 64'(k), 64'd10);
    check_idle("midrst_new", 16'd1, 1'b0);

    // Ordering violation on the word 5 following 7.
    fe = {32'd11, 32'd10, 32'd9, 32'd8, 32'd6, 32'd5, 32'd7, 32'd3, 32'd2, 32'd1};
    capture(fe, 1'b0);
    out_ready = 1'b1;
    repeat (4) tick;
    check("order_err_before", 64'(order_err), 64'd0);
    tick;
    check("order_err_on_beat", 64'(order_err), 64'(EXP_ERR));
    drain(4'b1111, k);
    check_idle("order_frame", 16'd2, EXP_ERR);
    capture(vecs[0].w, 1'b0);
    drain(4'b1111, k);
    check_idle("order_sticky", 16'd3, EXP_ERR);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_idle("order_cleared", 16'd0, 1'b0);

    // Counter wrap: preload near the top instead of streaming 65534 frames.
    capture(vecs[4].w, 1'b0);
    drain(4'b1111, k);
    check("wrap_pre_cnt", 64'(frame_cnt), 64'd1);
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    capture(vecs[1].w, 1'b0);
    drain(4'b1111, k);
    check("wrap_ffff", 64'(frame_cnt), 64'hFFFF);
    capture(vecs[0].w, 1'b0);
    drain(4'b1111, k);
    check("wrap_zero", 64'(frame_cnt), 64'h0000);
    capture(vecs[3].w, 1'b0);
    drain(4'b1111, k);
    check("wrap_one", 64'(frame_cnt), 64'h0001);

    tick;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
